// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered binary-to-one-hot decoder with optional scan mode (DECODER_SCAN_EN)
module onehot_decoder_seq #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  mode,
   input  logic [DWELL_W-1:0]    dwell,
   output logic [2**SEL_W-1:0]   y,
   output logic                  y_valid,
   output logic                  wrap
);

   localparam int OUT_W = 2**SEL_W;

`ifdef DECODER_SCAN_EN
   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
`else
   typedef enum logic [0:0] {IDLE, HOLD} state_t;
`endif

   state_t             state_q, state_d;
   logic [OUT_W-1:0]   y_d;
   logic               wrap_d;
   logic               accept;

`ifdef DECODER_SCAN_EN
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [SEL_W-1:0]   idx_nx;
`else
   logic               unused_inputs;
   assign unused_inputs = ^{mode, dwell};
`endif

   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [OUT_W-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

   // Ready follows enable; forced low while reset is asserted.
   assign in_ready = en & rst_n;
   assign accept   = in_valid & in_ready;

`ifdef DECODER_SCAN_EN
   assign idx_nx = idx_q + 1'b1;
`endif

   // Next-state and next-output logic; an accept always wins over a scan step.
   always_comb begin
      state_d = state_q;
      y_d     = y;
      wrap_d  = 1'b0;
`ifdef DECODER_SCAN_EN
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
`endif
      if (!en) begin
         state_d = IDLE;
         y_d     = '0;
`ifdef DECODER_SCAN_EN
         idx_d   = '0;
         cnt_d   = '0;
`endif
      end else if (accept) begin
         y_d = onehot(sel);
`ifdef DECODER_SCAN_EN
         if (mode) begin
            state_d = SCAN;
            idx_d   = sel;
            cnt_d   = '0;
            dwell_d = dwell;
         end else begin
            state_d = HOLD;
         end
`else
         state_d = HOLD;
`endif
      end
`ifdef DECODER_SCAN_EN
      else if (state_q == SCAN) begin
         if (cnt_q == dwell_q) begin
            cnt_d  = '0;
            idx_d  = idx_nx;
            y_d    = onehot(idx_nx);
            wrap_d = (idx_q == {SEL_W{1'b1}});
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
`endif
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         y       <= '0;
         y_valid <= 1'b0;
         wrap    <= 1'b0;
`ifdef DECODER_SCAN_EN
         idx_q   <= '0;
         cnt_q   <= '0;
         dwell_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         y       <= y_d;
         y_valid <= (state_d != IDLE);
         wrap    <= wrap_d;
`ifdef DECODER_SCAN_EN
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
`endif
      end
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - scoreboard bench for onehot_decoder_seq
module tb_onehot_decoder_seq;

   localparam int SEL_W   = 3;
   localparam int DWELL_W = 8;
   localparam int OUT_W   = 8;

`ifdef DECODER_SCAN_EN
   localparam bit SCAN_EN = 1'b1;
`else
   localparam bit SCAN_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               en = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [SEL_W-1:0]   sel = '0;
   logic               mode = 1'b0;
   logic [DWELL_W-1:0] dwell = '0;
   logic [OUT_W-1:0]   y;
   logic               y_valid;
   logic               wrap;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [OUT_W-1:0] y;
      logic             v;
      logic             w;
   } exp_t;

   exp_t exp_q[$];

   // behavioural reference: 0 idle, 1 hold, 2 scan; scan position derived from elapsed cycles
   int     m_state = 0;
   int     m_code  = 0;
   int     m_start = 0;
   int     m_dwell = 0;
   longint m_k     = 0;

   onehot_decoder_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .dwell(dwell), .y(y), .y_valid(y_valid), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t   e;
      longint pos;
      e.y = '0; e.v = 1'b0; e.w = 1'b0;
      if (m_state == 1) begin
         e.y = OUT_W'(1) << m_code;
         e.v = 1'b1;
      end else if (m_state == 2) begin
         pos = (m_start + m_k / (m_dwell + 1)) % OUT_W;
         e.y = OUT_W'(1) << pos;
         e.v = 1'b1;
         e.w = (m_k > 0) && (m_k % (m_dwell + 1) == 0) && (pos == 0);
      end
      return e;
   endfunction

   // one clock of stimulus: drive, check ready, take the edge, predict the outcome
   task automatic cyc(input logic e_i, input logic v_i, input logic [SEL_W-1:0] s_i,
                      input logic m_i, input logic [DWELL_W-1:0] d_i);
      en = e_i; in_valid = v_i; sel = s_i; mode = m_i; dwell = d_i;
      #1;
      check("in_ready", 64'(in_ready), 64'(e_i));
      @(posedge clk);
      if (!e_i) begin
         m_state = 0;
      end else if (v_i) begin
         if (m_i && SCAN_EN) begin
            m_state = 2; m_start = int'(s_i); m_dwell = int'(d_i); m_k = 0;
         end else begin
            m_state = 1; m_code = int'(s_i);
         end
      end else if (m_state == 2) begin
         m_k++;
      end
      exp_q.push_back(model_out());
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b1, 1'b0, SEL_W'($urandom), 1'b1, DWELL_W'($urandom));
   endtask

   // monitor: the DUT presents y/y_valid/wrap every cycle; compare against the oldest prediction
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("y", 64'(y), 64'(e.y));
         check("y_valid", 64'(y_valid), 64'(e.v));
         check("wrap", 64'(wrap), 64'(e.w));
         check("popcount", 64'($countones(y)), 64'(y_valid ? 1 : 0));
      end
   end

   initial begin
      // reset state
      #2;
      check("rst_y", 64'(y), 64'd0);
      check("rst_y_valid", 64'(y_valid), 64'd0);
      check("rst_wrap", 64'(wrap), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // decode sweep back-to-back
      for (int s = 0; s < OUT_W; s++)
         cyc(1'b1, 1'b1, SEL_W'(s), 1'b0, 8'd0);
      idle(2);

      // scan from 6 with dwell 2 through a wrap
      cyc(1'b1, 1'b1, 3'd6, 1'b1, 8'd2);
      idle(12);

      // override on the cycle a wrap is due
      cyc(1'b1, 1'b1, 3'd6, 1'b1, 8'd0);
      idle(1);
      cyc(1'b1, 1'b1, 3'd3, 1'b0, 8'd0);
      idle(3);

      // enable drop during scan with in_valid high
      cyc(1'b1, 1'b1, 3'd1, 1'b1, 8'd1);
      idle(2);
      cyc(1'b0, 1'b1, 3'd4, 1'b0, 8'd0);
      cyc(1'b0, 1'b1, 3'd5, 1'b1, 8'd0);
      cyc(1'b1, 1'b0, 3'd5, 1'b0, 8'd0);
      idle(3);

      // scan request that the default build treats as a plain decode
      cyc(1'b1, 1'b1, 3'd2, 1'b1, 8'd0);
      idle(20);

      // maximum dwell
      cyc(1'b1, 1'b1, 3'd7, 1'b1, 8'd255);
      idle(520);

      // asynchronous reset mid-HOLD
      cyc(1'b1, 1'b1, 3'd4, 1'b0, 8'd0);
      idle(2);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_y", 64'(y), 64'd0);
      check("async_rst_y_valid", 64'(y_valid), 64'd0);
      check("async_rst_wrap", 64'(wrap), 64'd0);
      m_state = 0;
      #1 rst_n = 1'b1;
      cyc(1'b1, 1'b1, 3'd5, 1'b0, 8'd0);
      @(negedge clk); #1;
      check("post_rst_sel5", 64'(y), 64'h20);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic e_r, v_r, m_r;
         logic [DWELL_W-1:0] d_r;
         e_r = ($urandom_range(0, 19) != 0);
         v_r = ($urandom_range(0, 9) < 3);
         m_r = 1'($urandom);
         d_r = ($urandom_range(0, 9) == 0) ? DWELL_W'($urandom) : DWELL_W'($urandom_range(0, 3));
         cyc(e_r, v_r, SEL_W'($urandom), m_r, d_r);
      end

      @(negedge clk); @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/onehot_decoder_seq.md
# onehot_decoder_seq

Registered, parametrised binary-to-one-hot decoder: the successor to the fixed 3-to-8 combinational decoder. It accepts a select code over a valid/ready handshake and holds the decoded one-hot output until the next accepted code. An optional scan mode walks the active output around all positions with a programmable dwell time. It drives chip-select, row-select and LED/scan-line fan-out wherever a registered, glitch-free one-hot bus is needed.

## Interface
Parameters:
- SEL_W, 3, select code width; OUT_W = 2**SEL_W (derived localparam, not overridable).
- DWELL_W, 8, width of the dwell count in scan mode.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; low forces idle.
- in_valid  in  1  select code valid.
- in_ready  out  1  block can accept a code; combinational, equal to en (0 while rst_n is low).
- sel  in  SEL_W  binary select code; for scan, the start position.
- mode  in  1  0 = decode/hold, 1 = scan; sampled on accept.
- dwell  in  DWELL_W  cycles per scan position minus 1; sampled on accept.
- y  out  OUT_W  registered one-hot output (all-zero when idle).
- y_valid  out  1  y holds a valid one-hot value.
- wrap  out  1  one-cycle pulse when the scan index wraps from OUT_W-1 to 0.

## Operation
- Accept means in_valid && in_ready at a rising edge.
- States are IDLE, HOLD and SCAN.
- IDLE:
  - y=0, y_valid=0.
  - Accept with mode=0 goes to HOLD. Accept with mode=1 goes to SCAN.
- HOLD:
  - y = 1<<sel of the last accepted code, y_valid=1, held indefinitely.
  - A new accept with mode=0 reloads y and stays in HOLD. A new accept with mode=1 goes to SCAN.
- SCAN:
  - Internal index idx and dwell counter cnt. On entry, idx=sel, cnt=0, and the dwell value is latched.
  - y = 1<<idx, y_valid=1.
  - Each cycle cnt increments. When cnt equals the latched dwell, cnt returns to 0 and idx advances by 1, so each position is held dwell+1 cycles.
  - Wrap: idx=OUT_W-1 advances to 0 and wrap pulses high in the same cycle that y shows bit 0.
  - An accept during SCAN overrides the scan: mode=0 goes to HOLD with the new code; mode=1 restarts the scan at the new sel with the new dwell.
- en=0, from any state:
  - The next edge forces IDLE, y=0, y_valid=0, wrap=0.
  - in_ready=0, so in_valid is ignored.
- Invariant: popcount(y) is 0 when y_valid=0 and exactly 1 when y_valid=1.

## Timing
- Reset (asynchronous assert):
  - y=0, y_valid=0, wrap=0, state IDLE, idx=0, cnt=0.
  - Deassertion is used synchronised externally; the first accept is possible at the first edge after release.
- Latency is 1 cycle: a code accepted at edge N appears on y/y_valid after edge N.
- Throughput: one code per cycle, with no bubbles between back-to-back accepts.
- Scan with dwell=0 advances every cycle. dwell=2**DWELL_W-1 gives the maximum hold of 2**DWELL_W cycles.
- Changes to dwell or mode outside an accept have no effect.
- Simultaneous events:
  - en=0 overrides in_valid.
  - An accept overrides a scan advance or wrap in the same cycle, and wrap is not pulsed.
- Reset mid-scan clears immediately, with no completion of the current dwell.

## Configuration
- DECODER_SCAN_EN defined: full behaviour as above.
- DECODER_SCAN_EN undefined:
  - The SCAN state, idx/cnt registers and dwell latch are removed.
  - mode is treated as 0, so every accept goes to HOLD.
  - dwell is ignored and wrap is tied to 0.
  - Ports are unchanged.

## Test plan
- Reset: assert rst_n=0 mid-HOLD -> y=0, y_valid=0, wrap=0 immediately, without waiting for clk; after release, accepting sel=5 gives y=8'b0010_0000 one cycle later.
- Decode sweep: SEL_W=3, accept sel=0..7 back-to-back with mode=0 -> y=1<<sel each following cycle; popcount check on every cycle.
- Scan: accept sel=6, mode=1, dwell=2 -> y=0x40 ×3 cycles, 0x80 ×3, 0x01 ×3 with wrap=1 only on the first 0x01 cycle, then 0x02.
- Override: during a scan, accept sel=3, mode=0 on the cycle a wrap is due -> next y=0x08 in HOLD, no wrap pulse.
- Enable: en=0 during SCAN with in_valid=1 -> in_ready=0, y=0, y_valid=0 next cycle; en=1 restores ready, with no output until a new accept.
- Build without DECODER_SCAN_EN: accept sel=2, mode=1, dwell=0 -> y=0x04 held for 20 cycles, wrap=0 throughout.
